// File: rtl/jtframe_dump_ctrl_if.sv
// Control/status bundle for the frame-windowed dump controller.
// The master side drives sync, arm/disarm and the per-channel window
// setup; the slave side (the controller) returns the frame count,
// the per-channel capture enables and the busy/done status.
interface jtframe_dump_ctrl_if #(
  parameter int CH = 4,
  parameter int FW = 32,
  parameter int LW = 16
);
  logic               vs;
  logic               arm;
  logic               disarm;
  logic [CH*FW-1:0]   start_frame;
  logic [CH*LW-1:0]   len;
  logic [FW-1:0]      frame_cnt;
  logic [CH-1:0]      dump_en;
  logic               busy;
  logic               done;

  modport master (
    output vs, arm, disarm, start_frame, len,
    input  frame_cnt, dump_en, busy, done
  );

  modport slave (
    input  vs, arm, disarm, start_frame, len,
    output frame_cnt, dump_en, busy, done
  );
endinterface

// File: rtl/jtframe_dump_ctrl.sv
// Frame-windowed dump controller.
// Counts frame boundaries derived from vs and opens, per channel, a
// capture window starting at a programmed frame and lasting a
// programmed number of frame boundaries (0 = open until disarm).
// A single done pulse marks the moment the last open window closes.
module jtframe_dump_ctrl #(
  parameter int CH     = 4,
  parameter int FW     = 32,
  parameter int LW     = 16,
  parameter int VSEDGE = 0
) (
  input  logic               clk,
  input  logic               rst,
  jtframe_dump_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACTIVE,
    S_DONE
  } state_e;

  logic          vs_l_q;
  logic          fe;
  logic [FW-1:0] cnt_q;
  logic [FW-1:0] cnt_d;
  logic [FW-1:0] cnt_inc;

  state_e        state_q [CH];
  state_e        state_d [CH];
  logic [FW-1:0] st_q    [CH];
  logic [FW-1:0] st_d    [CH];
  logic [LW-1:0] rem_q   [CH];
  logic [LW-1:0] rem_d   [CH];

  logic [CH-1:0] en_q;
  logic [CH-1:0] en_d;
  logic          done_q;
  logic          done_d;
  logic          close_any;
  logic          live_any;
  logic          busy_w;

  // Frame-edge strobe: compares the previous vs sample with the current one.
  assign fe = (VSEDGE != 0) ? (~vs_l_q & bus.vs) : (vs_l_q & ~bus.vs);

  // Saturating successor; the WAIT comparison uses this new value so the
  // window opens in the same cycle the counter shows the start frame.
  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + {{(FW-1){1'b0}}, 1'b1};
  assign cnt_d   = fe ? cnt_inc : cnt_q;

  // Per-channel window FSMs plus the "last window just closed" detector.
  always_comb begin
    state_d   = state_q;
    st_d      = st_q;
    rem_d     = rem_q;
    en_d      = en_q;
    close_any = 1'b0;
    live_any  = 1'b0;
    for (int n = 0; n < CH; n++) begin
      if (bus.disarm) begin
        // Abort wins over arm and fe; no done is generated.
        state_d[n] = S_IDLE;
        en_d[n]    = 1'b0;
      end else begin
        case (state_q[n])
          S_IDLE, S_DONE: begin
            // Load only: an fe in this same cycle is not compared yet.
            if (bus.arm) begin
              state_d[n] = S_WAIT;
              st_d[n]    = bus.start_frame[n*FW +: FW];
              rem_d[n]   = bus.len[n*LW +: LW];
            end
          end
          S_WAIT: begin
            // Catch-up: a start frame already passed opens on the next edge.
            if (fe && (st_q[n] <= cnt_inc)) begin
              state_d[n] = S_ACTIVE;
              en_d[n]    = 1'b1;
            end
          end
          S_ACTIVE: begin
            // Entry edge is not counted; rem==0 at entry means open-ended.
            if (fe && (rem_q[n] != '0)) begin
              rem_d[n] = rem_q[n] - LW'(1);
              if (rem_q[n] == LW'(1)) begin
                state_d[n] = S_DONE;
                en_d[n]    = 1'b0;
              end
            end
          end
          default: begin
            state_d[n] = S_IDLE;
          end
        endcase
      end
      if ((state_d[n] == S_DONE) && (state_q[n] != S_DONE)) close_any = 1'b1;
      if ((state_d[n] == S_WAIT) || (state_d[n] == S_ACTIVE)) live_any = 1'b1;
    end
    // Simultaneous closures collapse into one pulse; a closure while
    // another window is still pending produces none.
    done_d = close_any & ~live_any;
  end

  // Busy reflects any channel still waiting for or inside its window.
  always_comb begin
    busy_w = 1'b0;
    for (int n = 0; n < CH; n++) begin
      if ((state_q[n] == S_WAIT) || (state_q[n] == S_ACTIVE)) busy_w = 1'b1;
    end
    if (rst) busy_w = 1'b0;
  end

  // State registers; vs_l tracks vs even in reset so no phantom edge follows it.
  always_ff @(posedge clk) begin
    vs_l_q <= bus.vs;
    if (rst) begin
      cnt_q  <= '0;
      en_q   <= '0;
      done_q <= 1'b0;
      for (int n = 0; n < CH; n++) begin
        state_q[n] <= S_IDLE;
        st_q[n]    <= '0;
        rem_q[n]   <= '0;
      end
    end else begin
      cnt_q  <= cnt_d;
      en_q   <= en_d;
      done_q <= done_d;
      for (int n = 0; n < CH; n++) begin
        state_q[n] <= state_d[n];
        st_q[n]    <= st_d[n];
        rem_q[n]   <= rem_d[n];
      end
    end
  end

  assign bus.frame_cnt = cnt_q;
  assign bus.dump_en   = en_q;
  assign bus.busy      = busy_w;
  assign bus.done      = done_q;

endmodule
